mem_arbiter: RTL and testbench

- Shares the single 8-bit synchronous memory port (16-bit address, write enable) between two bus masters, e.g. the cpu core and a program loader / DMA engine.
- Registered req/gnt handshake per master. Round-robin arbitration with a bounded burst length.
- Routes write data and address to memory, and returns read data with a one-cycle-delayed valid strobe.

---
 rtl/mem_arbiter.sv | 154 +++++++++++++++
 tb/tb_mem_arbiter.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_arbiter.sv
// Two-master arbiter for one synchronous memory port: round-robin with a bounded burst.
// Define ARB_FIXED_PRIO_EN to give master 0 absolute priority instead.
module mem_arbiter #(
  parameter int ADDR_W    = 16,
  parameter int DATA_W    = 8,
  parameter int BURST_MAX = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              m0_req,
  input  logic              m0_we,
  input  logic [ADDR_W-1:0] m0_addr,
  input  logic [DATA_W-1:0] m0_wdata,
  output logic              m0_gnt,
  output logic              m0_rvalid,
  output logic [DATA_W-1:0] m0_rdata,
  input  logic              m1_req,
  input  logic              m1_we,
  input  logic [ADDR_W-1:0] m1_addr,
  input  logic [DATA_W-1:0] m1_wdata,
  output logic              m1_gnt,
  output logic              m1_rvalid,
  output logic [DATA_W-1:0] m1_rdata,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_do,
  output logic              mem_we,
  input  logic [DATA_W-1:0] mem_di
);

  localparam int CNT_W = $clog2(BURST_MAX + 1);
  localparam logic [CNT_W-1:0] CNT_SAT  = CNT_W'(BURST_MAX);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BURST_MAX - 1);

  typedef enum logic [1:0] {IDLE, OWN0, OWN1} state_e;

  state_e           state_q, state_d;
  logic             last1_q, last1_d;  // 1 when m1 was the last master served
  logic [CNT_W-1:0] burst_q, burst_d;
  logic             rvalid0_q, rvalid0_d;
  logic             rvalid1_q, rvalid1_d;

  logic own0, own1, acc0, acc1, burst_end;
  logic [CNT_W-1:0] burst_inc;

  assign own0 = (state_q == OWN0);
  assign own1 = (state_q == OWN1);
  assign acc0 = own0 & m0_req;
  assign acc1 = own1 & m1_req;

  always_comb begin
    mem_addr = '0;
    mem_do   = '0;
    if (own0) begin
      mem_addr = m0_addr;
      mem_do   = m0_wdata;
    end else if (own1) begin
      mem_addr = m1_addr;
      mem_do   = m1_wdata;
    end
  end

  assign mem_we = (acc0 & m0_we) | (acc1 & m1_we);

  // >= rather than == so a saturated owner still yields once the other master asks
  assign burst_end = (burst_q >= CNT_LAST);
  assign burst_inc = (burst_q == CNT_SAT) ? burst_q : burst_q + 1'b1;

  always_comb begin
    state_d   = state_q;
    last1_d   = last1_q;
    burst_d   = burst_q;
    rvalid0_d = acc0 & ~m0_we;
    rvalid1_d = acc1 & ~m1_we;
    case (state_q)
      IDLE: begin
        burst_d = '0;
        if (m0_req && m1_req) begin
`ifdef ARB_FIXED_PRIO_EN
          state_d = OWN0;
`else
          state_d = last1_q ? OWN0 : OWN1;
`endif
        end else if (m0_req) begin
          state_d = OWN0;
        end else if (m1_req) begin
          state_d = OWN1;
        end
      end
      OWN0: begin
        if (!m0_req) begin
          state_d = m1_req ? OWN1 : IDLE;
          last1_d = 1'b0;
          burst_d = '0;
        end
`ifndef ARB_FIXED_PRIO_EN
        else if (burst_end && m1_req) begin
          state_d = OWN1;
          last1_d = 1'b0;
          burst_d = '0;
        end
`endif
        else begin
          burst_d = burst_inc;
        end
      end
      OWN1: begin
        if (!m1_req) begin
          state_d = m0_req ? OWN0 : IDLE;
          last1_d = 1'b1;
          burst_d = '0;
        end
`ifdef ARB_FIXED_PRIO_EN
        else if (m0_req) begin
`else
        else if (burst_end && m0_req) begin
`endif
          state_d = OWN0;
          last1_d = 1'b1;
          burst_d = '0;
        end else begin
          burst_d = burst_inc;
        end
      end
      default: begin
        state_d = IDLE;
        burst_d = '0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      last1_q   <= 1'b1;
      burst_q   <= '0;
      rvalid0_q <= 1'b0;
      rvalid1_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      last1_q   <= last1_d;
      burst_q   <= burst_d;
      rvalid0_q <= rvalid0_d;
      rvalid1_q <= rvalid1_d;
    end
  end

  assign m0_gnt    = own0;
  assign m1_gnt    = own1;
  assign m0_rvalid = rvalid0_q;
  assign m1_rvalid = rvalid1_q;
  assign m0_rdata  = rvalid0_q ? mem_di : '0;
  assign m1_rdata  = rvalid1_q ? mem_di : '0;

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: behavioural sync memory, read-data scoreboard and directed scenarios.
module tb_mem_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        m0_req, m0_we, m1_req, m1_we;
  logic [15:0] m0_addr, m1_addr;
  logic [7:0]  m0_wdata, m1_wdata;
  logic        m0_gnt, m0_rvalid, m1_gnt, m1_rvalid;
  logic [7:0]  m0_rdata, m1_rdata;
  logic [15:0] mem_addr;
  logic [7:0]  mem_do, mem_di;
  logic        mem_we;

  int err_cnt = 0;
  int chk_cnt = 0;

  logic [7:0] mem     [0:65535];
  logic [7:0] exp_mem [0:65535];
  logic [7:0] q0[$];
  logic [7:0] q1[$];
  logic       pend0 = 1'b0;
  logic       pend1 = 1'b0;

  mem_arbiter #(.ADDR_W(16), .DATA_W(8), .BURST_MAX(4)) dut (
    .clk(clk), .rst(rst),
    .m0_req(m0_req), .m0_we(m0_we), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
    .m0_gnt(m0_gnt), .m0_rvalid(m0_rvalid), .m0_rdata(m0_rdata),
    .m1_req(m1_req), .m1_we(m1_we), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
    .m1_gnt(m1_gnt), .m1_rvalid(m1_rvalid), .m1_rdata(m1_rdata),
    .mem_addr(mem_addr), .mem_do(mem_do), .mem_we(mem_we), .mem_di(mem_di)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (mem_we) mem[mem_addr] <= mem_do;
    mem_di <= mem[mem_addr];
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    chk_cnt++;
    if (got !== exp) begin
      err_cnt++;
      $display("FAIL %s: got=%0h expected=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    cyc();
    rst = 1'b1;
    m0_req = 1'b0;
    m1_req = 1'b0;
    cyc();
    cyc();
    rst = 1'b0;
  endtask

  // Scoreboard: reads are queued at their access cycle and retired on the following cycle.
  always @(negedge clk) begin
    logic [7:0] e;
    if (rst) begin
      check("rst_m0_rvalid", m0_rvalid, 0);
      check("rst_m1_rvalid", m1_rvalid, 0);
      check("rst_gnt", {m0_gnt, m1_gnt}, 0);
      pend0 = 1'b0;
      pend1 = 1'b0;
      q0.delete();
      q1.delete();
    end else begin
      check("m0_rvalid", m0_rvalid, pend0);
      if (pend0) begin
        e = q0.pop_front();
        check("m0_rdata", m0_rdata, e);
      end else check("m0_rdata_idle", m0_rdata, 0);
      check("m1_rvalid", m1_rvalid, pend1);
      if (pend1) begin
        e = q1.pop_front();
        check("m1_rdata", m1_rdata, e);
      end else check("m1_rdata_idle", m1_rdata, 0);
      check("gnt_onehot", m0_gnt & m1_gnt, 0);
      pend0 = m0_gnt & m0_req & ~m0_we;
      pend1 = m1_gnt & m1_req & ~m1_we;
      if (pend0) q0.push_back(exp_mem[m0_addr]);
      if (pend1) q1.push_back(exp_mem[m1_addr]);
      if (m0_gnt && m0_req && m0_we) exp_mem[m0_addr] = m0_wdata;
      if (m1_gnt && m1_req && m1_we) exp_mem[m1_addr] = m1_wdata;
      $display("cyc t=%0t gnt=%b%b we=%b addr=%h do=%h rv=%b%b", $time, m1_gnt, m0_gnt,
               mem_we, mem_addr, mem_do, m1_rvalid, m0_rvalid);
    end
  end

  initial begin
    for (int i = 0; i < 65536; i++) begin
      mem[i]     = 8'h00;
      exp_mem[i] = 8'h00;
    end
    mem[16'h0020]     = 8'h3C;
    exp_mem[16'h0020] = 8'h3C;
    rst = 1'b1;
    m0_req = 1'b0; m0_we = 1'b0; m0_addr = '0; m0_wdata = '0;
    m1_req = 1'b0; m1_we = 1'b0; m1_addr = '0; m1_wdata = '0;

    // Reset state, then m0 alone: write 0xA5 to 0x0100, read it back
    cyc();
    #1;
    check("rst_state_gnt", {m0_gnt, m1_gnt}, 0);
    check("rst_state_we", mem_we, 0);
    check("rst_state_addr", mem_addr, 0);
    cyc();
    rst = 1'b0;
    m0_req = 1'b1; m0_we = 1'b1; m0_addr = 16'h0100; m0_wdata = 8'hA5;
    #1;
    check("t1_gnt_c0", m0_gnt, 0);
    cyc();
    #1;
    check("t1_gnt_c1", m0_gnt, 1);
    check("t1_mem_we", mem_we, 1);
    check("t1_mem_addr", mem_addr, 16'h0100);
    check("t1_mem_do", mem_do, 8'hA5);
    check("t1_m1_gnt", m1_gnt, 0);
    cyc();
    m0_we = 1'b0;
    #1;
    check("t1_rd_gnt", m0_gnt, 1);
    check("t1_rd_we", mem_we, 0);
    cyc();
    m0_req = 1'b0;
    #1;
    check("t1_rvalid", m0_rvalid, 1);
    check("t1_rdata", m0_rdata, 8'hA5);
    check("t1_m1_gnt_end", m1_gnt, 0);
    cyc();
    #1;
    check("t1_idle", {m0_gnt, m1_gnt, m0_rvalid}, 0);

    // Simultaneous request after reset: m0 first, m1 right after m0 drops
    do_reset();
    m0_req = 1'b1; m0_we = 1'b1; m0_addr = 16'h0200; m0_wdata = 8'h11;
    m1_req = 1'b1; m1_we = 1'b1; m1_addr = 16'h0300; m1_wdata = 8'h22;
    #1;
    check("t2_c0_gnt", {m0_gnt, m1_gnt}, 0);
    cyc();
    #1;
    check("t2_c1_gnt", {m0_gnt, m1_gnt}, 2'b10);
    cyc();
    m0_req = 1'b0;
    #1;
    check("t2_c2_gnt", {m0_gnt, m1_gnt}, 2'b10);
    check("t2_c2_we", mem_we, 0);
    cyc();
    #1;
    check("t2_c3_gnt", {m0_gnt, m1_gnt}, 2'b01);
    check("t2_c3_addr", mem_addr, 16'h0300);
    check("t2_c3_do", mem_do, 8'h22);
    check("t2_c3_we", mem_we, 1);
    cyc();
    m1_req = 1'b0;

`ifndef ARB_FIXED_PRIO_EN
    // Continuous contention: 4 accesses each, alternating, no idle gap
    do_reset();
    m0_req = 1'b1; m0_we = 1'b0; m0_addr = 16'h0100;
    m1_req = 1'b1; m1_we = 1'b0; m1_addr = 16'h0300;
    for (int c = 1; c <= 24; c++) begin
      logic own0;
      cyc();
      m0_addr = c[0] ? 16'h0100 : 16'h0200;
      m1_addr = c[0] ? 16'h0300 : 16'h0020;
      own0 = (((c - 1) / 4) % 2) == 0;
      #1;
      check("t3_m0_gnt", m0_gnt, own0);
      check("t3_m1_gnt", m1_gnt, !own0);
    end
    cyc();
    m0_req = 1'b0;
    m1_req = 1'b0;
    cyc();
    cyc();
`endif

    // Reset while an m1 read is in flight drops its rvalid
    do_reset();
    m1_req = 1'b1; m1_we = 1'b0; m1_addr = 16'h0020;
    cyc();
    #1;
    check("t4_m1_gnt", m1_gnt, 1);
    cyc();
    rst = 1'b1;
    m1_req = 1'b0;
    #1;
    check("t4_rst_gnt", m1_gnt, 0);
    check("t4_rst_rvalid", m1_rvalid, 0);
    cyc();
    rst = 1'b0;
    for (int c = 0; c < 3; c++) begin
      cyc();
      #1;
      check("t4_post_rvalid", m1_rvalid, 0);
      check("t4_post_idle", {m0_gnt, m1_gnt}, 0);
    end

`ifdef ARB_FIXED_PRIO_EN
    // m0 preempts m1 mid-burst and keeps the bus past the burst limit
    do_reset();
    m1_req = 1'b1; m1_we = 1'b0; m1_addr = 16'h0020;
    cyc();
    #1;
    check("t5_m1_c1", m1_gnt, 1);
    cyc();
    m0_req = 1'b1; m0_we = 1'b0; m0_addr = 16'h0100;
    #1;
    check("t5_m1_c2", m1_gnt, 1);
    for (int c = 0; c < 10; c++) begin
      cyc();
      #1;
      check("t5_m0_hold", {m0_gnt, m1_gnt}, 2'b10);
    end
    cyc();
    m0_req = 1'b0;
    #1;
    check("t5_m0_drop", {m0_gnt, m1_gnt}, 2'b10);
    cyc();
    #1;
    check("t5_m1_resume", {m0_gnt, m1_gnt}, 2'b01);
    cyc();
    m1_req = 1'b0;
    cyc();
`endif

    cyc();
    cyc();
    check("sb_drain", q0.size() + q1.size(), 0);
    $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
    $finish;
  end

endmodule
